// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator register: Q-op select encoding and
// the priority order in which simultaneous Q-op strobes are resolved.
package acc_pkg;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_CLR,
        OP_LD,
        OP_ADD,
        OP_INC,
        OP_DEC,
        OP_SHR,
        OP_SHL,
        OP_CMA
    } op_e;

    localparam int unsigned N_QOPS = 8;

    // Index 0 is the highest priority; the strobe vector uses the same bit order.
    localparam op_e Q_OP_PRIO [N_QOPS] = '{
        OP_CLR, OP_LD, OP_ADD, OP_INC, OP_DEC, OP_SHR, OP_SHL, OP_CMA
    };

    // Ops that write E themselves; a concurrent CLE/CME is dropped for them.
    function automatic logic op_owns_e(input op_e op);
        return (op == OP_ADD) || (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/acc_op_sel.sv
// Priority encoder from the eight Q-op strobes to a single op select,
// plus a flag for more than one strobe asserted.
module acc_op_sel
    import acc_pkg::*;
(
    input  logic [N_QOPS-1:0] strb_i,
    output op_e               op_o,
    output logic              multi_o
);

    always_comb begin
        op_o = OP_NONE;
        // Walk from lowest to highest priority so the highest set strobe wins.
        for (int i = N_QOPS - 1; i >= 0; i--) begin
            if (strb_i[i]) begin
                op_o = Q_OP_PRIO[i];
            end
        end
    end

    assign multi_o = |(strb_i & (strb_i - N_QOPS'(1)));

endmodule

// File: rtl/acc_reg_n.sv
// Parametrised accumulator / general-purpose register with extend bit E,
// prioritised Q-ops, E-ops and a registered multi-op conflict flag.
module acc_reg_n
    import acc_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit              SATURATE  = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Data,
    input  logic             LD,
    input  logic             CLR,
    input  logic             INC,
    input  logic             DEC,
    input  logic             ADD,
    input  logic             SHR,
    input  logic             SHL,
    input  logic             CMA,
    input  logic             CLE,
    input  logic             CME,
    output logic [WIDTH-1:0] Q,
    output logic             E,
    output logic             ZERO,
    output logic             MSB,
    output logic             CONFLICT
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             e_q, e_d;
    logic             conflict_q, conflict_d;
    logic [N_QOPS-1:0] strb;
    op_e              op_sel;
    logic             multi_op;

    assign strb = {CMA, SHL, SHR, DEC, INC, ADD, LD, CLR};

    acc_op_sel u_op_sel (
        .strb_i  (strb),
        .op_o    (op_sel),
        .multi_o (multi_op)
    );

    always_comb begin
        q_d = q_q;
        e_d = e_q;
        unique case (op_sel)
            OP_CLR: q_d = '0;
            OP_LD:  q_d = Data;
            OP_ADD: {e_d, q_d} = {1'b0, q_q} + {1'b0, Data};
            OP_INC: begin
                if (!(SATURATE && (q_q == ALL_ONES))) q_d = q_q + ONE;
            end
            OP_DEC: begin
                if (!(SATURATE && (q_q == '0))) q_d = q_q - ONE;
            end
            OP_SHR: begin
                q_d = {e_q, q_q[WIDTH-1:1]};
                e_d = q_q[0];
            end
            OP_SHL: begin
                q_d = {q_q[WIDTH-2:0], e_q};
                e_d = q_q[WIDTH-1];
            end
            OP_CMA: q_d = ~q_q;
            default: ;
        endcase
        if (!op_owns_e(op_sel)) begin
            if (CLE)      e_d = 1'b0;
            else if (CME) e_d = ~e_q;
        end
        conflict_d = multi_op | (CLE & CME);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q        <= RESET_VAL;
            e_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            e_q        <= e_d;
            conflict_q <= conflict_d;
        end
    end

    assign Q        = q_q;
    assign E        = e_q;
    assign ZERO     = (q_q == '0);
    assign MSB      = q_q[WIDTH-1];
    assign CONFLICT = conflict_q;

endmodule

// File: tb/tb_acc_reg_n.sv
// Self-checking bench: two 8-bit instances (wrap / saturate+reset value)
// driven in lockstep and compared against an arithmetic reference model.
module tb_acc_reg_n;

    localparam logic [9:0] B_CLR = 10'h001;
    localparam logic [9:0] B_LD  = 10'h002;
    localparam logic [9:0] B_ADD = 10'h004;
    localparam logic [9:0] B_INC = 10'h008;
    localparam logic [9:0] B_DEC = 10'h010;
    localparam logic [9:0] B_SHR = 10'h020;
    localparam logic [9:0] B_SHL = 10'h040;
    localparam logic [9:0] B_CMA = 10'h080;
    localparam logic [9:0] B_CLE = 10'h100;
    localparam logic [9:0] B_CME = 10'h200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] ops = '0;
    logic [7:0] data = '0;

    logic [7:0] q0, q1;
    logic       e0, e1, z0, z1, m0, m1, c0, c1;

    int errors = 0;
    int checks = 0;

    // Reference state per instance: index 0 wraps with reset value 0,
    // index 1 saturates with reset value 8'h10.
    int mq [2];
    int me [2];
    int mc [2];
    int rv [2] = '{0, 16};
    int sat [2] = '{0, 1};

    always #5 clk = ~clk;

    acc_reg_n #(.WIDTH(8), .RESET_VAL(8'h00), .SATURATE(1'b0)) dut0 (
        .CLK(clk), .RST(rst), .Data(data),
        .LD(ops[1]), .CLR(ops[0]), .INC(ops[3]), .DEC(ops[4]), .ADD(ops[2]),
        .SHR(ops[5]), .SHL(ops[6]), .CMA(ops[7]), .CLE(ops[8]), .CME(ops[9]),
        .Q(q0), .E(e0), .ZERO(z0), .MSB(m0), .CONFLICT(c0)
    );

    acc_reg_n #(.WIDTH(8), .RESET_VAL(8'h10), .SATURATE(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .Data(data),
        .LD(ops[1]), .CLR(ops[0]), .INC(ops[3]), .DEC(ops[4]), .ADD(ops[2]),
        .SHR(ops[5]), .SHL(ops[6]), .CMA(ops[7]), .CLE(ops[8]), .CME(ops[9]),
        .Q(q1), .E(e1), .ZERO(z1), .MSB(m1), .CONFLICT(c1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the behavioural model using the currently driven inputs.
    task automatic model_edge(input int k);
        int n;
        int s;
        bit e_taken;
        if (rst) begin
            mq[k] = rv[k];
            me[k] = 0;
            mc[k] = 0;
            return;
        end
        n = 0;
        for (int b = 0; b < 8; b++) n += int'(ops[b]);
        mc[k] = (n > 1 || (ops[8] && ops[9])) ? 1 : 0;
        e_taken = 0;
        if (ops[0])      mq[k] = 0;
        else if (ops[1]) mq[k] = int'(data);
        else if (ops[2]) begin
            s = mq[k] + int'(data);
            me[k] = s / 256;
            mq[k] = s % 256;
            e_taken = 1;
        end else if (ops[3]) begin
            if (mq[k] == 255) mq[k] = sat[k] ? 255 : 0;
            else mq[k] = mq[k] + 1;
        end else if (ops[4]) begin
            if (mq[k] == 0) mq[k] = sat[k] ? 0 : 255;
            else mq[k] = mq[k] - 1;
        end else if (ops[5]) begin
            s = mq[k] % 2;
            mq[k] = mq[k] / 2 + me[k] * 128;
            me[k] = s;
            e_taken = 1;
        end else if (ops[6]) begin
            s = mq[k] / 128;
            mq[k] = (mq[k] * 2) % 256 + me[k];
            me[k] = s;
            e_taken = 1;
        end else if (ops[7]) mq[k] = 255 - mq[k];
        if (!e_taken) begin
            if (ops[8])      me[k] = 0;
            else if (ops[9]) me[k] = 1 - me[k];
        end
    endtask

    task automatic step(input logic r, input logic [9:0] o, input logic [7:0] d);
        rst  = r;
        ops  = o;
        data = d;
        @(posedge clk);
        #1;
        model_edge(0);
        model_edge(1);
        check("q0", int'(q0), mq[0]);
        check("e0", int'(e0), me[0]);
        check("c0", int'(c0), mc[0]);
        check("z0", int'(z0), (mq[0] == 0) ? 1 : 0);
        check("m0", int'(m0), mq[0] / 128);
        check("q1", int'(q1), mq[1]);
        check("e1", int'(e1), me[1]);
        check("c1", int'(c1), mc[1]);
        check("z1", int'(z1), (mq[1] == 0) ? 1 : 0);
        check("m1", int'(m1), mq[1] / 128);
    endtask

    initial begin
        logic [9:0] ro;
        for (int k = 0; k < 2; k++) begin
            mq[k] = 0; me[k] = 0; mc[k] = 0;
        end

        step(1'b1, B_LD, 8'hAA);
        check("rst_q0", int'(q0), 'h00);
        check("rst_z0", int'(z0), 1);
        check("rst_q1", int'(q1), 'h10);
        step(1'b0, B_LD, 8'hFF);
        step(1'b0, B_INC, 8'h00);
        check("inc_wrap", int'(q0), 'h00);
        check("inc_sat", int'(q1), 'hFF);
        step(1'b0, B_DEC, 8'h00);
        check("dec_wrap", int'(q0), 'hFF);

        step(1'b0, B_LD, 8'hC8);
        step(1'b0, B_ADD, 8'h64);
        check("add1_q", int'(q0), 'h2C);
        check("add1_e", int'(e0), 1);
        step(1'b0, B_ADD, 8'h01);
        check("add2_q", int'(q0), 'h2D);
        check("add2_e", int'(e0), 0);

        step(1'b0, B_LD | B_CLE, 8'h81);
        step(1'b0, B_SHR, 8'h00);
        check("shr_q", int'(q0), 'h40);
        check("shr_e", int'(e0), 1);
        step(1'b0, B_SHL, 8'h00);
        check("shl_q", int'(q0), 'h81);
        step(1'b0, B_CMA, 8'h00);
        check("cma_q", int'(q0), 'h7E);
        check("cma_msb", int'(m0), 0);

        step(1'b0, B_LD, 8'h09);
        step(1'b0, B_LD | B_INC, 8'h05);
        check("pri_q", int'(q0), 'h05);
        check("pri_conf", int'(c0), 1);
        step(1'b0, 10'h000, 8'h00);
        check("conf_clr", int'(c0), 0);

        step(1'b0, B_LD | B_CLE, 8'h80);
        step(1'b0, B_SHL | B_CME, 8'h00);
        check("shlcme_q", int'(q0), 'h00);
        check("shlcme_e", int'(e0), 1);
        step(1'b0, B_CLE | B_CME, 8'h00);
        check("clecme_e", int'(e0), 0);
        check("clecme_c", int'(c0), 1);

        for (int i = 0; i < 400; i++) begin
            ro = '0;
            for (int b = 0; b < 10; b++) ro[b] = ($urandom_range(0, 4) == 0);
            step($urandom_range(0, 30) == 0, ro, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acc_reg_n.md
Name: acc_reg_n

Overview:
- Parametrised general-purpose/accumulator register for the Mano datapath; successor to the fixed 8-bit load-only data register.
- Adds clear, increment, decrement, add-with-carry, shifts and complement, with a carry/extend bit E and status flags.
- Serves as the AC (with E), or as DR/AR/PC by tying unused controls low.
- Sits on the common bus, driven by control-unit decode.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RESET_VAL, 0, value loaded into Q on RST (WIDTH bits).
- SATURATE, 0, 1 = INC holds at all-ones and DEC holds at zero; 0 = wrap-around.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous active-high reset.
- Data  input  WIDTH  load operand / ADD addend.
- LD  input  1  load Q <= Data.
- CLR  input  1  clear Q <= 0.
- INC  input  1  increment Q.
- DEC  input  1  decrement Q.
- ADD  input  1  {E,Q} <= Q + Data.
- SHR  input  1  circulate right through E.
- SHL  input  1  circulate left through E.
- CMA  input  1  Q <= ~Q.
- CLE  input  1  E <= 0.
- CME  input  1  E <= ~E.
- Q  output  WIDTH  register contents.
- E  output  1  extend/carry bit.
- ZERO  output  1  combinational (Q == 0).
- MSB  output  1  combinational Q[WIDTH-1] (sign).
- CONFLICT  output  1  registered; high for the cycle after more than one Q-op was asserted.

Behaviour:
- Clock CLK, single domain. Reset is synchronous and active-high on RST.
- Reset: Q = RESET_VAL, E = 0, CONFLICT = 0. RST overrides every op in the same edge.
- Q-ops in priority order, high to low: CLR > LD > ADD > INC > DEC > SHR > SHL > CMA. Only the highest asserted op executes. Lower ones are ignored, not queued.
- Latency: results are visible on Q/E one edge after the op is sampled. ZERO and MSB follow Q combinationally.
- No op asserted: Q and E hold.
- ADD: {E,Q} <= {1'b0,Q} + {1'b0,Data}. E takes the carry-out. Unaffected by SATURATE.
- INC: Q+1, E unchanged.
  - Q = all-ones with SATURATE=0: Q -> 0.
  - Q = all-ones with SATURATE=1: Q holds.
- DEC: Q-1, E unchanged.
  - Q = 0 with SATURATE=0: Q -> all-ones.
  - Q = 0 with SATURATE=1: Q holds.
- SHR: Q <= {E, Q[WIDTH-1:1]}, E <= Q[0].
- SHL: Q <= {Q[WIDTH-2:0], E}, E <= Q[WIDTH-1].
- E-ops:
  - CLE has priority over CME.
  - An E-op executes only if the winning Q-op is not ADD, SHR or SHL; those ops own E that cycle.
  - With CLR, LD, INC, DEC, CMA or no Q-op, the E-op applies in the same edge.
- CONFLICT: registered (count of asserted Q-ops > 1). Cleared by RST.
  - CLE+CME together also sets CONFLICT.
  - Diagnostic only; it never blocks execution.
- All arithmetic is modulo 2^WIDTH except the ADD carry into E. No X-propagation from unused inputs when their op is not selected.

Decomposition:
- Shared package acc_pkg:
  - op-select enum: OP_NONE, OP_CLR, OP_LD, OP_ADD, OP_INC, OP_DEC, OP_SHR, OP_SHL, OP_CMA.
  - Q-op priority ordering constant.
- One sub-module, acc_op_sel: combinational priority encoder from the eight Q-op strobes to the enum, plus a multi-hot detect output.
- acc_reg_n holds the datapath mux, the Q/E registers and the CONFLICT register.

Test Plan (WIDTH=8, RESET_VAL=0 unless stated):
- RST with LD=1, Data=8'hAA -> after edge Q=8'h00, E=0, CONFLICT=0, ZERO=1. With RESET_VAL=8'h10, Q=8'h10.
- LD 8'hFF, then INC:
  - SATURATE=0 -> Q=8'h00, ZERO=1, E unchanged.
  - SATURATE=1 -> Q=8'hFF.
  - Then DEC from 8'h00 with SATURATE=0 -> Q=8'hFF.
- LD 8'hC8, then ADD Data=8'h64 -> Q=8'h2C, E=1. Next ADD Data=8'h01 -> Q=8'h2D, E=0.
- Q=8'h81, E=0:
  - SHR -> Q=8'h40, E=1.
  - SHL -> Q=8'h81, E=0.
  - CMA -> Q=8'h7E, MSB=0.
- LD=1, INC=1, Data=8'h05, Q=8'h09 in the same cycle -> Q=8'h05, CONFLICT=1 for one cycle, then 0.
- CME with SHL and Q=8'h80, E=0 -> Q=8'h00, E=1 (the shift wins E, CME is dropped). CLE+CME with no Q-op -> E=0, CONFLICT=1.
